// File: rtl/syn_event_serializer_pkg.sv
// Shared types and synapse-field layout for the synaptic event serializer.
// A 32-bit word carries 8 synapses of {map, weight[2:0]}.
package syn_event_serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int SYN_PER_WORD = 8;
   localparam int WBITS        = 3;
   localparam int MAP_BIT      = 3;
   localparam int SYN_BITS     = 4;
   localparam int EVT_WBITS    = 4;

   // Negating a zero magnitude yields 4'b0000, so no separate negative-zero case exists.
   function automatic logic [EVT_WBITS-1:0] signed_weight(input logic sign,
                                                          input logic [WBITS-1:0] w);
      logic [EVT_WBITS-1:0] mag;
      mag = {1'b0, w};
      return sign ? (~mag + 4'd1) : mag;
   endfunction

endpackage

// File: rtl/syn_prio_enc8.sv
// Lowest-set-bit encoder over 8 request bits; purely combinational.
// index is 0 when no bit is set, so qualify it with any.
module syn_prio_enc8 (
   input  logic [7:0] req,
   output logic [2:0] index,
   output logic       any
);

   always_comb begin
      index = 3'd0;
      any   = |req;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) index = i[2:0];
      end
   end

endmodule

// File: rtl/syn_event_serializer.sv
// Captures one synaptic word and emits its enabled synapses as events, lowest index first.
// Event valid one cycle after capture, one event per cycle; holds fields while NEUR_EVT_READY is low.
module syn_event_serializer
   import syn_event_serializer_pkg::*;
#(
   parameter int SKIP_ZERO = 1,
   parameter int N         = 256
) (
   input  logic                 CLK,
   input  logic                 RSTN_syncn,
   input  logic                 SPI_GATE_ACTIVITY_sync,
   input  logic                 SYN_WORD_VALID,
   output logic                 SYN_WORD_READY,
   input  logic [12:0]          SYN_WORD_ADDR,
   input  logic [31:0]          SYNARRAY_RDATA,
   input  logic                 SYN_SIGN,
   output logic                 NEUR_EVT_VALID,
   input  logic                 NEUR_EVT_READY,
   output logic [$clog2(N)-1:0] NEUR_EVT_ADDR,
   output logic [7:0]           NEUR_EVT_PRE,
   output logic [EVT_WBITS-1:0] NEUR_EVT_WEIGHT,
   output logic                 BUSY,
   output logic [15:0]          EVT_CNT
);

   state_t                                state_q, state_d;
   logic [SYN_PER_WORD-1:0]               mask_q, mask_d, cap_mask, hit;
   logic [SYN_PER_WORD-1:0][WBITS-1:0]    w_q;
   logic [4:0]                            grp_q;
   logic [7:0]                            pre_q;
   logic                                  sign_q;
   logic [15:0]                           cnt_q;
   logic [2:0]                            idx;
   logic                                  any;
   logic                                  capture, evt_hs;

   syn_prio_enc8 u_prio (
      .req   (mask_q),
      .index (idx),
      .any   (any)
   );

   // A synapse is pending if mapped, not a skipped zero weight, and activity is not gated.
   always_comb begin
      cap_mask = '0;
      for (int i = 0; i < SYN_PER_WORD; i++) begin
         cap_mask[i] = SYNARRAY_RDATA[SYN_BITS*i + MAP_BIT]
                       && !((SKIP_ZERO != 0) && (SYNARRAY_RDATA[SYN_BITS*i +: WBITS] == '0))
                       && !SPI_GATE_ACTIVITY_sync;
      end
   end

   assign SYN_WORD_READY = (state_q == IDLE);
   assign BUSY           = (state_q == EMIT);
   assign capture        = SYN_WORD_VALID && SYN_WORD_READY;
   assign NEUR_EVT_VALID = (state_q == EMIT) && any;
   assign evt_hs         = NEUR_EVT_VALID && NEUR_EVT_READY;
   assign hit            = 8'd1 << idx;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE: begin
            if (SYN_WORD_VALID) begin
               mask_d = cap_mask;
               if (|cap_mask) state_d = EMIT;
            end
         end
         EMIT: begin
            if (evt_hs) begin
               // Gating lets the in-flight event finish but drops the rest of the word.
               mask_d = SPI_GATE_ACTIVITY_sync ? '0 : (mask_q & ~hit);
               if (mask_d == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN_syncn) begin
      if (!RSTN_syncn) begin
         state_q <= IDLE;
         mask_q  <= '0;
         w_q     <= '0;
         grp_q   <= '0;
         pre_q   <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         if (capture) begin
            grp_q  <= SYN_WORD_ADDR[4:0];
            pre_q  <= SYN_WORD_ADDR[12:5];
            sign_q <= SYN_SIGN;
            for (int i = 0; i < SYN_PER_WORD; i++) begin
               w_q[i] <= SYNARRAY_RDATA[SYN_BITS*i +: WBITS];
            end
         end
         if (evt_hs) cnt_q <= cnt_q + 16'd1;
      end
   end

   assign NEUR_EVT_ADDR   = NEUR_EVT_VALID ? {grp_q, idx} : '0;
   assign NEUR_EVT_PRE    = NEUR_EVT_VALID ? pre_q : '0;
   assign NEUR_EVT_WEIGHT = NEUR_EVT_VALID ? signed_weight(sign_q, w_q[idx]) : '0;
   assign EVT_CNT         = cnt_q;

endmodule

// File: tb/tb_syn_event_serializer.sv
// Directed bench: two instances (SKIP_ZERO=1 and 0) share stimulus; events are logged on the falling edge.
module tb_syn_event_serializer;

   logic        CLK = 1'b0;
   logic        RSTN_syncn;
   logic        gate;
   logic        word_vld;
   logic [12:0] word_addr;
   logic [31:0] rdata;
   logic        sign;
   logic        evt_rdy;

   logic        rdy_a, vld_a, busy_a, rdy_b, vld_b, busy_b;
   logic [7:0]  addr_a, pre_a, addr_b, pre_b;
   logic [3:0]  w_a, w_b;
   logic [15:0] cnt_a, cnt_b;

   int tests_run = 0;
   int tests_failed = 0;
   logic [19:0] qa[$];
   logic [19:0] qb[$];
   logic        mon_en = 1'b1;
   logic        stab_en = 1'b0;
   logic        prev_stall = 1'b0;
   logic [19:0] prev_fields = '0;

   always #5 CLK = ~CLK;

   syn_event_serializer #(.SKIP_ZERO(1), .N(256)) dut_a (
      .CLK(CLK), .RSTN_syncn(RSTN_syncn), .SPI_GATE_ACTIVITY_sync(gate),
      .SYN_WORD_VALID(word_vld), .SYN_WORD_READY(rdy_a), .SYN_WORD_ADDR(word_addr),
      .SYNARRAY_RDATA(rdata), .SYN_SIGN(sign), .NEUR_EVT_VALID(vld_a),
      .NEUR_EVT_READY(evt_rdy), .NEUR_EVT_ADDR(addr_a), .NEUR_EVT_PRE(pre_a),
      .NEUR_EVT_WEIGHT(w_a), .BUSY(busy_a), .EVT_CNT(cnt_a));

   syn_event_serializer #(.SKIP_ZERO(0), .N(256)) dut_b (
      .CLK(CLK), .RSTN_syncn(RSTN_syncn), .SPI_GATE_ACTIVITY_sync(gate),
      .SYN_WORD_VALID(word_vld), .SYN_WORD_READY(rdy_b), .SYN_WORD_ADDR(word_addr),
      .SYNARRAY_RDATA(rdata), .SYN_SIGN(sign), .NEUR_EVT_VALID(vld_b),
      .NEUR_EVT_READY(evt_rdy), .NEUR_EVT_ADDR(addr_b), .NEUR_EVT_PRE(pre_b),
      .NEUR_EVT_WEIGHT(w_b), .BUSY(busy_b), .EVT_CNT(cnt_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs only change just after a rising edge, so what is seen here is what the next edge sees.
   always @(negedge CLK) begin
      if (mon_en && RSTN_syncn) begin
         if (vld_a && evt_rdy) qa.push_back({addr_a, pre_a, w_a});
         if (vld_b && evt_rdy) qb.push_back({addr_b, pre_b, w_b});
      end
      if (stab_en && prev_stall) begin
         check("stall_vld", {31'd0, vld_a}, 32'd1);
         check("stall_fields", {12'd0, addr_a, pre_a, w_a}, {12'd0, prev_fields});
      end
      prev_stall  = vld_a && !evt_rdy && RSTN_syncn;
      prev_fields = {addr_a, pre_a, w_a};
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_a || busy_b) && n < 100) begin
         tick();
         n++;
      end
      check("idle_reached", {31'd0, busy_a | busy_b}, 32'd0);
   endtask

   // Returns one cycle after the capture edge.
   task automatic send_word(input logic [12:0] a, input logic [31:0] d, input logic s);
      int n = 0;
      while (!(rdy_a && rdy_b) && n < 100) begin
         tick();
         n++;
      end
      word_vld = 1'b1; word_addr = a; rdata = d; sign = s;
      tick();
      word_vld = 1'b0;
   endtask

   initial begin
      int n;
      RSTN_syncn = 1'b0; gate = 1'b0; word_vld = 1'b0; word_addr = '0;
      rdata = '0; sign = 1'b0; evt_rdy = 1'b1;
      #12;
      check("rst_ready", {31'd0, rdy_a}, 32'd1);
      check("rst_valid", {31'd0, vld_a}, 32'd0);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_cnt", {16'd0, cnt_a}, 32'd0);
      check("rst_fields", {12'd0, addr_a, pre_a, w_a}, 32'd0);
      @(posedge CLK); #1; RSTN_syncn = 1'b1;
      tick();

      // Word with a +7 at synapse 0 and a mapped zero weight at synapse 7.
      qa.delete(); qb.delete();
      send_word(13'h0021, 32'h8000_000F, 1'b0);
      check("s1_valid_next", {31'd0, vld_a}, 32'd1);
      check("s1_ready_low", {31'd0, rdy_a}, 32'd0);
      check("s1_busy", {31'd0, busy_a}, 32'd1);
      check("s1_fields", {12'd0, addr_a, pre_a, w_a}, {12'd0, 8'd8, 8'd1, 4'd7});
      wait_idle();
      check("s1_a_nevt", qa.size(), 32'd1);
      check("s1_b_nevt", qb.size(), 32'd2);
      if (qb.size() == 2) begin
         check("s1_b_evt0", {12'd0, qb[0]}, {12'd0, 8'd8, 8'd1, 4'd7});
         check("s1_b_evt1", {12'd0, qb[1]}, {12'd0, 8'd15, 8'd1, 4'd0});
      end
      check("s1_cnt_a", {16'd0, cnt_a}, 32'd1);
      check("s1_cnt_b", {16'd0, cnt_b}, 32'd2);

      // Full inhibitory word, one event per cycle.
      qa.delete(); qb.delete();
      send_word(13'h0043, 32'hFFFF_FFFF, 1'b1);
      check("s2_valid_next", {31'd0, vld_a}, 32'd1);
      repeat (7) tick();
      check("s2_valid_at7", {31'd0, vld_a}, 32'd1);
      tick();
      check("s2_valid_drop", {31'd0, vld_a}, 32'd0);
      check("s2_ready_back", {31'd0, rdy_a}, 32'd1);
      check("s2_nevt", qa.size(), 32'd8);
      for (int i = 0; i < 8 && i < qa.size(); i++)
         check($sformatf("s2_evt%0d", i), {12'd0, qa[i]}, {12'd0, 8'd24 + 8'(i), 8'd2, 4'b1001});
      check("s2_cnt", {16'd0, cnt_a}, 32'd9);

      // Alternating downstream ready; fields must hold while stalled.
      qa.delete(); qb.delete();
      evt_rdy = 1'b0;
      send_word(13'h1FFF, 32'h0000_A0C9, 1'b0);
      stab_en = 1'b1;
      n = 0;
      while (busy_a && n < 40) begin
         evt_rdy = n[0];
         tick();
         n++;
      end
      stab_en = 1'b0; evt_rdy = 1'b1;
      check("s3_done", {31'd0, busy_a}, 32'd0);
      check("s3_nevt", qa.size(), 32'd3);
      if (qa.size() == 3) begin
         check("s3_evt0", {12'd0, qa[0]}, {12'd0, 8'd248, 8'd255, 4'd1});
         check("s3_evt1", {12'd0, qa[1]}, {12'd0, 8'd249, 8'd255, 4'd4});
         check("s3_evt2", {12'd0, qa[2]}, {12'd0, 8'd251, 8'd255, 4'd2});
      end
      check("s3_cnt", {16'd0, cnt_a}, 32'd12);

      // No mapping bits, then a full word while gated: both consumed without events.
      qa.delete(); qb.delete();
      send_word(13'h0100, 32'h7777_7777, 1'b0);
      check("s4_ready", {31'd0, rdy_a}, 32'd1);
      check("s4_valid", {31'd0, vld_a}, 32'd0);
      gate = 1'b1;
      send_word(13'h0100, 32'hFFFF_FFFF, 1'b0);
      check("s4g_ready", {31'd0, rdy_a}, 32'd1);
      check("s4g_busy", {31'd0, busy_a}, 32'd0);
      gate = 1'b0;
      tick();
      check("s4_nevt", qa.size(), 32'd0);
      check("s4_cnt", {16'd0, cnt_a}, 32'd12);

      // Gate raised after the second handshake: third event completes, rest dropped.
      qa.delete(); qb.delete();
      send_word(13'h0005, 32'hFFFF_FFFF, 1'b0);
      tick();
      tick();
      gate = 1'b1;
      tick();
      check("s5_valid_off", {31'd0, vld_a}, 32'd0);
      check("s5_idle", {31'd0, rdy_a}, 32'd1);
      gate = 1'b0;
      tick();
      check("s5_nevt", qa.size(), 32'd3);
      if (qa.size() == 3)
         for (int i = 0; i < 3; i++)
            check($sformatf("s5_evt%0d", i), {12'd0, qa[i]}, {12'd0, 8'd40 + 8'(i), 8'd0, 4'd7});
      check("s5_cnt", {16'd0, cnt_a}, 32'd15);

      // Run the counters up to the wrap point; instance b stays exactly one ahead.
      mon_en = 1'b0;
      word_addr = '0; rdata = 32'hFFFF_FFFF; sign = 1'b0; word_vld = 1'b1;
      n = 0;
      while (cnt_a < 16'hFFF0 && n < 80000) begin
         tick();
         n++;
      end
      word_vld = 1'b0;
      wait_idle();
      n = 0;
      while (cnt_a != 16'hFFFE && n < 20) begin
         send_word(13'h0000, 32'h0000_000F, 1'b0);
         wait_idle();
         n++;
      end
      check("s6_cnt_a_pre", {16'd0, cnt_a}, 32'h0000_FFFE);
      check("s6_cnt_b_pre", {16'd0, cnt_b}, 32'h0000_FFFF);
      send_word(13'h0000, 32'h0000_000F, 1'b0);
      wait_idle();
      check("s6_cnt_a_ffff", {16'd0, cnt_a}, 32'h0000_FFFF);
      check("s6_cnt_b_wrap", {16'd0, cnt_b}, 32'd0);

      // Reset in the middle of a stalled word.
      evt_rdy = 1'b0;
      send_word(13'h0067, 32'hFFFF_FFFF, 1'b1);
      check("s6_emit", {31'd0, busy_a}, 32'd1);
      check("s6_w", {28'd0, w_a}, 32'h9);
      #2 RSTN_syncn = 1'b0;
      #1;
      check("s6_rst_valid", {31'd0, vld_a}, 32'd0);
      check("s6_rst_fields", {12'd0, addr_a, pre_a, w_a}, 32'd0);
      check("s6_rst_cnt", {16'd0, cnt_a}, 32'd0);
      check("s6_rst_busy", {31'd0, busy_a}, 32'd0);
      check("s6_rst_ready", {31'd0, rdy_a}, 32'd1);
      tick(); tick();
      RSTN_syncn = 1'b1; evt_rdy = 1'b1;
      qa.delete(); qb.delete(); mon_en = 1'b1;
      repeat (5) tick();
      check("s6_no_replay", qa.size(), 32'd0);
      check("s6_post_cnt", {16'd0, cnt_a}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/syn_event_serializer.md
SYN_EVENT_SERIALIZER -- requirements
Module: syn_event_serializer

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 1: when 1, enabled synapses with a zero 3-bit weight produce no event.
REQ-002 SHALL have parameter N, default 256: the post-synaptic neuron count, which sets the event address width log2(N)=8.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port RSTN_syncn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port SPI_GATE_ACTIVITY_sync, input, 1 bit: configuration gate; suppresses event generation.
REQ-007 SHALL have port SYN_WORD_VALID, input, 1 bit: a synaptic word is present on SYNARRAY_RDATA.
REQ-008 SHALL have port SYN_WORD_READY, output, 1 bit: the block can capture a word.
REQ-009 SHALL have port SYN_WORD_ADDR, input, 13 bits: the synapse word address; [12:5] is the pre-neuron and [4:0] is the post-neuron group.
REQ-010 SHALL have port SYNARRAY_RDATA, input, 32 bits: 8 synapses of 4 bits each, where bit 4i+3 is the mapping bit and bits 4i+2:4i are the weight.
REQ-011 SHALL have port SYN_SIGN, input, 1 bit: 1 means an inhibitory pre-neuron (negative weight).
REQ-012 SHALL have port NEUR_EVT_VALID, output, 1 bit: an event is presented to the neuron core.
REQ-013 SHALL have port NEUR_EVT_READY, input, 1 bit: the neuron core accepts the event.
REQ-014 SHALL have port NEUR_EVT_ADDR, output, 8 bits: the post-neuron index {ADDR[4:0], i[2:0]}.
REQ-015 SHALL have port NEUR_EVT_PRE, output, 8 bits: the pre-neuron index, ADDR[12:5].
REQ-016 SHALL have port NEUR_EVT_WEIGHT, output, 4 bits: the signed two's-complement weight, range -7..+7.
REQ-017 SHALL have port BUSY, output, 1 bit: a word is captured and not yet fully emitted.
REQ-018 SHALL have port EVT_CNT, output, 16 bits: the number of accepted events, wrapping.

Function
REQ-019 SHALL implement states IDLE and EMIT; SYN_WORD_READY=1 only in IDLE.
REQ-020 On VALID&READY, the block SHALL register the address, sign, weights and a pending mask; mask bit i = mapping[i] & ~(SKIP_ZERO & weight[i]==0) & ~SPI_GATE_ACTIVITY_sync.
REQ-021 A captured mask of zero SHALL keep the state in IDLE with no event; the word is consumed in one cycle.
REQ-022 A nonzero mask SHALL move the state to EMIT; NEUR_EVT_VALID SHALL rise the cycle after capture.
REQ-023 In EMIT, the presented event SHALL be the lowest-index set mask bit.
REQ-024 Weight = SIGN ? -{0,w} : {0,w}, in 4 bits; a negative zero SHALL be emitted as 4'b0000.
REQ-025 VALID and ADDR/PRE/WEIGHT SHALL stay stable until READY; a handshake SHALL clear that mask bit and increment EVT_CNT, with wrap from 16'hFFFF to 0.
REQ-026 Throughput SHALL be one event per cycle when READY is held high; NEUR_EVT_VALID SHALL drop the cycle after the last handshake.
REQ-027 Back-to-back: the state SHALL return to IDLE on the last handshake, and the next word SHALL be capturable the following cycle.
REQ-028 If SPI_GATE_ACTIVITY_sync rises in EMIT, the event presented at that moment SHALL still complete its handshake, the remaining mask SHALL clear, and the state SHALL then return to IDLE.
REQ-029 SYN_WORD_VALID while not ready SHALL be ignored; the upstream side holds the word.
REQ-030 BUSY SHALL equal (state==EMIT).

Reset
REQ-031 On assertion of RSTN_syncn=0, the block SHALL immediately go to IDLE, clear the mask, set NEUR_EVT_VALID=0, NEUR_EVT_ADDR/PRE/WEIGHT=0, EVT_CNT=0, BUSY=0 and SYN_WORD_READY=1, even mid-word.
REQ-032 An event lost mid-word to reset SHALL not be replayed.

Structure
REQ-033 A shared package SHALL hold the state encoding, the synapse-field constants (SYN_PER_WORD=8, WBITS=3, MAP_BIT=3) and the event weight width of 4.
REQ-034 One sub-module, syn_prio_enc8, SHALL provide the 8-bit lowest-set-bit encoder, with outputs index[2:0] and any.

Verification
REQ-035 Scenario: ADDR=13'h0021, RDATA=32'h8000_000F, SIGN=0, READY=1 -> events post 8 w=+7 and post 15 w=0 only if SKIP_ZERO=0, with pre=1.
REQ-036 Scenario: RDATA=32'hFFFF_FFFF, SIGN=1, READY=1 -> 8 consecutive events, w=-7 (4'b1001), posts {ADDR[4:0],0..7}, EVT_CNT+=8.
REQ-037 Scenario: READY toggled 1/0 during a word -> VALID and fields are stable while READY=0, with no duplicate or lost events.
REQ-038 Scenario: RDATA=32'h7777_7777 (mapping bits clear) -> no events and READY continuously 1.
REQ-039 Scenario: gate asserted after the 2nd handshake of an 8-event word -> the 3rd event completes, then no further events, then IDLE.
REQ-040 Scenario: reset asserted in EMIT with EVT_CNT=16'hFFFF -> all outputs take their reset values asynchronously; a pre-test wrap check shows 16'hFFFF+1=0.
